alu_result_collector: RTL and testbench
=======================================

Name: alu_result_collector

Overview:
- Consumer end of the ALU32 interface: takes each result the ALU produces (out, carryout, overflow, zero), tagged with its 4-bit function code op1.
- Buffers results in a small FIFO and presents them downstream on a valid/ready stream.
- Keeps sticky carry/overflow flags, a result counter, and a counter of results dropped because the buffer was full.
- Sits between the ALU32 datapath and the writeback/trace logic.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the accepted-result and dropped-result counters.

Ports:
- clk  input  1  clock; all logic updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- alu_valid  input  1  ALU result valid this cycle.
- alu_op  input  4  function code (op1) that produced the result.
- alu_out  input  32  ALU result.
- alu_carryout  input  1  ALU carry out.
- alu_overflow  input  1  ALU signed overflow.
- alu_zero  input  1  ALU zero flag.
- alu_ready  output  1  FIFO can accept an entry (not full).
- res_valid  output  1  head FIFO entry is valid.
- res_ready  input  1  downstream accepts the head entry.
- res_data  output  32  head entry result.
- res_op  output  4  head entry function code.
- res_flags  output  3  head entry flags, {carryout, overflow, zero}.
- sticky_carry  output  1  set by any accepted entry with carryout=1.
- sticky_ovf  output  1  set by any accepted entry with overflow=1.
- clr_sticky  input  1  clears both sticky flags.
- acc_cnt  output  CNT_W  number of entries accepted; saturates at all-ones.
- drop_cnt  output  CNT_W  number of results dropped; saturates at all-ones.

Behaviour:
- Reset, synchronous with rst=1 at a rising edge:
  - FIFO emptied; pointers and occupancy cleared.
  - res_valid=0; res_data, res_op and res_flags = 0.
  - sticky flags = 0; both counters = 0.
  - Reset mid-operation discards all stored entries; no entry is output in the cycle after reset.
- Push: alu_valid && alu_ready stores {alu_op, alu_out, alu_carryout, alu_overflow, alu_zero} at the write pointer.
- Drop: alu_valid && !alu_ready drops the result and increments drop_cnt.
  - The ALU cannot stall, so drop is the only option.
  - A dropped result does not affect the sticky flags or acc_cnt.
- alu_ready = (occupancy != DEPTH). It is combinational from registered state only; it does not look ahead to a pop in the same cycle.
- Pop: res_valid && res_ready advances the read pointer.
- Head outputs:
  - res_valid = (occupancy != 0).
  - res_data, res_op and res_flags show the head entry combinationally from storage.
  - When empty they are 0.
  - While res_valid=1 and res_ready=0, they hold stable.
- Latency: an entry pushed in cycle N is visible with res_valid=1 in cycle N+1.
- Simultaneous push and pop:
  - Allowed whenever alu_ready=1 and res_valid=1.
  - Occupancy is unchanged.
  - Both pointers advance.
- When full, a pop in the same cycle as alu_valid does not rescue the input: the input is dropped.
- Pointers wrap modulo DEPTH. Occupancy is tracked by a separate counter of log2(DEPTH)+1 bits.
- Sticky flags:
  - On a push, sticky_carry |= alu_carryout and sticky_ovf |= alu_overflow.
  - clr_sticky clears both.
  - If clr_sticky and a flag-setting push occur in the same cycle, set wins and the flag reads 1 next cycle.
- Counters: acc_cnt increments on a push, drop_cnt on a drop. Each saturates at 2^CNT_W-1 and does not wrap.
- No function-code decoding: alu_op is carried through as an opaque tag.

Test Plan:
- Reset, then one push with alu_op=0, alu_out=32'h80000000, carry=0, ovf=1, zero=0, res_ready=1 -> next cycle res_valid=1, res_data=32'h80000000, res_op=0, res_flags=3'b010; sticky_ovf=1; acc_cnt=1; the entry pops and res_valid=0 the cycle after.
- res_ready=0; push 5 results 32'h1..32'h5 back-to-back (DEPTH=4) -> alu_ready falls after the 4th push; 5th result dropped; drop_cnt=1, acc_cnt=4; then raise res_ready -> outputs 1,2,3,4 in order, one per cycle, then res_valid=0.
- Hold FIFO at occupancy 2; push and pop every cycle for 10 cycles with incrementing data -> occupancy stays 2; output order matches input order; pointer wrap exercised with no loss.
- Push alu_out=0, zero=1, carry=1 in the same cycle as clr_sticky=1 -> sticky_carry=1 (set wins); res_flags=3'b101; next cycle clr_sticky alone -> sticky_carry=0, sticky_ovf=0.
- With 3 entries stored, assert rst for one cycle -> res_valid=0, alu_ready=1, both counters 0; a subsequent push of 32'h0000000F is output as the first entry.
- Force acc_cnt to saturate (CNT_W=4, 17 accepted pushes with draining) -> acc_cnt holds at 4'hF.

Source files
------------

// File: rtl/alu_result_collector.sv
// Collects ALU32 results into a DEPTH-entry FIFO; a push is visible on res_* the next cycle.
// The ALU cannot stall, so results arriving while full are dropped and counted; res_ready stalls the head.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          push, pop;

  // Ready looks only at registered occupancy; a same-cycle pop never frees a slot.
  assign in_rdy  = (occ_q != OCC_FULL);
  assign out_vld = (occ_q != '0);
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;
  assign out_dat = out_vld ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      occ_d = occ_q + (AW+1)'(1);
    else if (pop && !push) occ_d = occ_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_dat;
  end
endmodule

module alu_result_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [3:0]       alu_op,
  input  logic [31:0]      alu_out,
  input  logic             alu_carryout,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             alu_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [3:0]       res_op,
  output logic [2:0]       res_flags,
  output logic             sticky_carry,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] drop_cnt
);
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] dat;
    logic [2:0]  flags;
  } entry_t;

  entry_t           in_ent, head_ent;
  logic             push, drop;
  logic             sticky_carry_q, sticky_carry_d, sticky_ovf_q, sticky_ovf_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, drop_cnt_q, drop_cnt_d;

  assign in_ent = '{op: alu_op, dat: alu_out, flags: {alu_carryout, alu_overflow, alu_zero}};

  sync_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (alu_valid),
    .in_rdy  (alu_ready),
    .in_dat  (in_ent),
    .out_vld (res_valid),
    .out_rdy (res_ready),
    .out_dat (head_ent)
  );

  assign push = alu_valid && alu_ready;
  assign drop = alu_valid && !alu_ready;

  assign res_data  = head_ent.dat;
  assign res_op    = head_ent.op;
  assign res_flags = head_ent.flags;

  always_comb begin
    // Set beats clear when both happen in the same cycle.
    sticky_carry_d = (sticky_carry_q && !clr_sticky) || (push && alu_carryout);
    sticky_ovf_d   = (sticky_ovf_q && !clr_sticky) || (push && alu_overflow);
    acc_cnt_d      = acc_cnt_q;
    drop_cnt_d     = drop_cnt_q;
    if (push && (acc_cnt_q != '1))  acc_cnt_d  = acc_cnt_q + CNT_W'(1);
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_carry_q <= 1'b0;
      sticky_ovf_q   <= 1'b0;
      acc_cnt_q      <= '0;
      drop_cnt_q     <= '0;
    end else begin
      sticky_carry_q <= sticky_carry_d;
      sticky_ovf_q   <= sticky_ovf_d;
      acc_cnt_q      <= acc_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign sticky_carry = sticky_carry_q;
  assign sticky_ovf   = sticky_ovf_q;
  assign acc_cnt      = acc_cnt_q;
  assign drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_alu_result_collector.sv
// Randomized plus directed bench for alu_result_collector against a queue-based reference model.
module tb_alu_result_collector;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             alu_valid;
  logic [3:0]       alu_op;
  logic [31:0]      alu_out;
  logic             alu_carryout, alu_overflow, alu_zero;
  logic             alu_ready, res_valid, res_ready;
  logic [31:0]      res_data;
  logic [3:0]       res_op;
  logic [2:0]       res_flags;
  logic             sticky_carry, sticky_ovf, clr_sticky;
  logic [CNT_W-1:0] acc_cnt, drop_cnt;

  alu_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_op       (alu_op),
    .alu_out      (alu_out),
    .alu_carryout (alu_carryout),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .alu_ready    (alu_ready),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_op       (res_op),
    .res_flags    (res_flags),
    .sticky_carry (sticky_carry),
    .sticky_ovf   (sticky_ovf),
    .clr_sticky   (clr_sticky),
    .acc_cnt      (acc_cnt),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: each entry is {op, data, carry, ovf, zero}.
  logic [38:0] mq[$];
  bit          m_sc, m_so;
  int          m_acc, m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Compare outputs against the model, clock once, then advance the model.
  task automatic cycle();
    logic [38:0] head;
    bit          do_pop, do_push, do_drop;
    head = (mq.size() != 0) ? mq[0] : 39'h0;
    chk("res_valid", 64'(res_valid), 64'(mq.size() != 0));
    chk("alu_ready", 64'(alu_ready), 64'(mq.size() != DEPTH));
    chk("res_data", 64'(res_data), 64'(head[34:3]));
    chk("res_op", 64'(res_op), 64'(head[38:35]));
    chk("res_flags", 64'(res_flags), 64'(head[2:0]));
    chk("sticky_carry", 64'(sticky_carry), 64'(m_sc));
    chk("sticky_ovf", 64'(sticky_ovf), 64'(m_so));
    chk("acc_cnt", 64'(acc_cnt), 64'(m_acc));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    do_pop  = (mq.size() != 0) && res_ready;
    do_push = alu_valid && (mq.size() != DEPTH);
    do_drop = alu_valid && (mq.size() == DEPTH);
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_sc = 0; m_so = 0; m_acc = 0; m_drop = 0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({alu_op, alu_out, alu_carryout, alu_overflow, alu_zero});
      if (clr_sticky) begin m_sc = 0; m_so = 0; end
      if (do_push && alu_carryout) m_sc = 1;
      if (do_push && alu_overflow) m_so = 1;
      if (do_push && m_acc < CNT_MAX) m_acc++;
      if (do_drop && m_drop < CNT_MAX) m_drop++;
    end
  endtask

  task automatic drive(input bit v, input logic [3:0] op, input logic [31:0] d,
                       input bit c, input bit o, input bit z, input bit rr, input bit clr);
    alu_valid = v; alu_op = op; alu_out = d;
    alu_carryout = c; alu_overflow = o; alu_zero = z;
    res_ready = rr; clr_sticky = clr;
    cycle();
  endtask

  task automatic idle(input bit rr, input int n);
    for (int i = 0; i < n; i++) drive(0, 4'h0, 32'h0, 0, 0, 0, rr, 0);
  endtask

  initial begin
    rst = 1; alu_valid = 0; alu_op = 0; alu_out = 0;
    alu_carryout = 0; alu_overflow = 0; alu_zero = 0;
    res_ready = 0; clr_sticky = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    m_sc = 0; m_so = 0; m_acc = 0; m_drop = 0;

    // Single push with overflow, drained immediately.
    drive(1, 4'h0, 32'h8000_0000, 0, 1, 0, 1, 0);
    chk("first_flags", 64'(res_flags), 64'h2);
    idle(1, 2);

    // Overfill with downstream stalled, then drain in order.
    for (int i = 1; i <= 5; i++) drive(1, 4'(i), 32'(i), 0, 0, 0, 0, 0);
    chk("drop_after_overfill", 64'(drop_cnt), 64'd1);
    idle(1, 6);

    // Hold occupancy at 2 with concurrent push/pop across pointer wrap.
    for (int i = 0; i < 2; i++) drive(1, 4'h3, 32'h100 + 32'(i), 0, 0, 0, 0, 0);
    for (int i = 2; i < 12; i++) drive(1, 4'h3, 32'h100 + 32'(i), 0, 0, 0, 1, 0);
    idle(1, 3);

    // Set beats clear, then clear alone.
    drive(1, 4'h7, 32'h0, 1, 0, 1, 0, 1);
    chk("set_wins", 64'(sticky_carry), 64'd1);
    drive(0, 4'h0, 32'h0, 0, 0, 0, 1, 1);
    idle(1, 2);

    // Reset with entries stored discards them.
    for (int i = 0; i < 3; i++) drive(1, 4'h9, 32'hA0 + 32'(i), 1, 1, 0, 0, 0);
    rst = 1;
    idle(0, 1);
    rst = 0;
    chk("post_rst_valid", 64'(res_valid), 64'd0);
    drive(1, 4'h1, 32'h0000_000F, 0, 0, 0, 0, 0);
    chk("post_rst_head", 64'(res_data), 64'hF);
    idle(1, 2);

    // Saturate acc_cnt.
    for (int i = 0; i < 17; i++) drive(1, 4'hC, 32'h5000 + 32'(i), 0, 0, 0, 1, 0);
    idle(1, 5);
    chk("acc_saturated", 64'(acc_cnt), 64'hF);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 9) < 7, 4'($urandom), $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
    end
    rst = 0;
    idle(1, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
